// File: rtl/mem_test_ctrl.sv
// -----------------------------------------------------------------------------
// mem_test_ctrl
// Sequencer for the memTest device. It drives an external address accumulator
// (enable / control-reset) and consumes its address. It runs a write pass, then
// a read-verify pass, over addresses 0..p_LAST_ADDR. The data written to each
// address is (addr XOR p_PATTERN). It reports pass/fail, a saturating error
// count, the first failing address and a sticky timeout flag.
//
// Optional build macro: MEMTEST_INV_PASS_EN
//   When defined, a second write+read pass follows the first read pass. The
//   second pass uses inverted data ~(addr XOR p_PATTERN). Errors from both
//   passes accumulate into the same counter.
//
// Ports:
//   i_CLK, i_RST              clock, asynchronous active-high reset
//   i_START                   start pulse (honoured only in IDLE or DONE)
//   i_ADDR                    current address from the accumulator
//   o_ACC_ENABLE              accumulator advance
//   o_ACC_RST_CONTROL         accumulator return-to-zero
//   o_MEM_WE / o_MEM_RE       memory write strobe / 1-cycle read request
//   o_MEM_ADDR, o_MEM_WDATA   memory address and write data
//   i_MEM_RDATA, i_MEM_RVALID read data and its valid
//   o_BUSY, o_DONE, o_PASS    test status
//   o_ERR_COUNT               mismatches + timeouts, saturating
//   o_FIRST_ERR_ADDR          address of the first error
//   o_TIMEOUT                 sticky: at least one read timed out
// -----------------------------------------------------------------------------
module mem_test_ctrl #(
    parameter int                      p_ADDR_WIDTH = 8,
    parameter int                      p_DATA_WIDTH = 8,
    parameter int                      p_LAST_ADDR  = 255,
    parameter logic [p_DATA_WIDTH-1:0] p_PATTERN    = 8'hA5,
    parameter int                      p_TIMEOUT    = 16,
    parameter int                      p_ERR_WIDTH  = 8
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_START,
    input  logic [p_ADDR_WIDTH-1:0] i_ADDR,
    output logic                    o_ACC_ENABLE,
    output logic                    o_ACC_RST_CONTROL,
    output logic                    o_MEM_WE,
    output logic                    o_MEM_RE,
    output logic [p_ADDR_WIDTH-1:0] o_MEM_ADDR,
    output logic [p_DATA_WIDTH-1:0] o_MEM_WDATA,
    input  logic [p_DATA_WIDTH-1:0] i_MEM_RDATA,
    input  logic                    i_MEM_RVALID,
    output logic                    o_BUSY,
    output logic                    o_DONE,
    output logic                    o_PASS,
    output logic [p_ERR_WIDTH-1:0]  o_ERR_COUNT,
    output logic [p_ADDR_WIDTH-1:0] o_FIRST_ERR_ADDR,
    output logic                    o_TIMEOUT
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INIT      = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_RD_INIT   = 3'd3;
    localparam logic [2:0] S_READ_REQ  = 3'd4;
    localparam logic [2:0] S_READ_WAIT = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam int TMO_W = $clog2(p_TIMEOUT + 1);

    // Saturating increment of the error counter (holds at all-ones).
    function automatic logic [p_ERR_WIDTH-1:0] sat_inc(input logic [p_ERR_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Reference data for an address: the address is resized to the data width
    // (truncated or zero-extended) before the XOR with the pattern.
    function automatic logic [p_DATA_WIDTH-1:0] expected(input logic [p_ADDR_WIDTH-1:0] a);
        return p_DATA_WIDTH'(a) ^ p_PATTERN;
    endfunction

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [p_DATA_WIDTH-1:0] exp_data;
    logic [p_ERR_WIDTH-1:0] err_nxt;
    logic                   is_last;
    logic                   rsp_vld;
    logic                   tmo_hit;
    logic                   rd_done;
    logic                   err_evt;
    logic                   start_ok;

`ifdef MEMTEST_INV_PASS_EN
    logic                   inv_pass;
    assign exp_data = inv_pass ? ~expected(i_ADDR) : expected(i_ADDR);
`else
    assign exp_data = expected(i_ADDR);
`endif

    assign is_last  = (i_ADDR == p_ADDR_WIDTH'(p_LAST_ADDR));
    assign start_ok = i_START && ((state == S_IDLE) || (state == S_DONE));
    assign rsp_vld  = (state == S_READ_WAIT) && i_MEM_RVALID;
    // Timeout fires on the p_TIMEOUT-th READ_WAIT cycle with no response.
    assign tmo_hit  = (state == S_READ_WAIT) && !i_MEM_RVALID &&
                      (tmo_cnt == TMO_W'(p_TIMEOUT - 1));
    assign rd_done  = rsp_vld || tmo_hit;
    assign err_evt  = (rsp_vld && (i_MEM_RDATA != exp_data)) || tmo_hit;
    assign err_nxt  = err_evt ? sat_inc(o_ERR_COUNT) : o_ERR_COUNT;

    // Memory / accumulator strobes and next-state decode, from state and i_ADDR.
    always_comb begin
        state_nxt         = state;
        o_ACC_ENABLE      = 1'b0;
        o_ACC_RST_CONTROL = 1'b0;
        o_MEM_WE          = 1'b0;
        o_MEM_RE          = 1'b0;
        o_MEM_ADDR        = '0;
        o_MEM_WDATA       = '0;
        case (state)
            S_IDLE, S_DONE: begin
                if (i_START) state_nxt = S_INIT;
            end
            S_INIT: begin
                o_ACC_RST_CONTROL = 1'b1;
                state_nxt         = S_WRITE;
            end
            S_WRITE: begin
                o_MEM_WE    = 1'b1;
                o_MEM_ADDR  = i_ADDR;
                o_MEM_WDATA = exp_data;
                if (is_last) state_nxt = S_RD_INIT;
                else         o_ACC_ENABLE = 1'b1;
            end
            S_RD_INIT: begin
                o_ACC_RST_CONTROL = 1'b1;
                state_nxt         = S_READ_REQ;
            end
            S_READ_REQ: begin
                o_MEM_RE   = 1'b1;
                o_MEM_ADDR = i_ADDR;
                state_nxt  = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                if (rd_done) begin
                    if (is_last) begin
`ifdef MEMTEST_INV_PASS_EN
                        state_nxt = inv_pass ? S_DONE : S_INIT;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        o_ACC_ENABLE = 1'b1;
                        state_nxt    = S_READ_REQ;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered state and status.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state            <= S_IDLE;
            tmo_cnt          <= '0;
            o_BUSY           <= 1'b0;
            o_DONE           <= 1'b0;
            o_PASS           <= 1'b0;
            o_ERR_COUNT      <= '0;
            o_FIRST_ERR_ADDR <= '0;
            o_TIMEOUT        <= 1'b0;
        end else begin
            state <= state_nxt;

            if (start_ok) begin
                o_BUSY           <= 1'b1;
                o_DONE           <= 1'b0;
                o_PASS           <= 1'b0;
                o_ERR_COUNT      <= '0;
                o_FIRST_ERR_ADDR <= '0;
                o_TIMEOUT        <= 1'b0;
            end

            if (state == S_READ_REQ)
                tmo_cnt <= '0;
            else if ((state == S_READ_WAIT) && !i_MEM_RVALID && !tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (err_evt) begin
                o_ERR_COUNT <= err_nxt;
                if (o_ERR_COUNT == '0) o_FIRST_ERR_ADDR <= i_ADDR;
                if (tmo_hit)           o_TIMEOUT        <= 1'b1;
            end

            // Final verdict includes an error on the very last read.
            if ((state == S_READ_WAIT) && (state_nxt == S_DONE)) begin
                o_BUSY <= 1'b0;
                o_DONE <= 1'b1;
                o_PASS <= (err_nxt == '0);
            end
        end
    end

`ifdef MEMTEST_INV_PASS_EN
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            inv_pass <= 1'b0;
        else if (start_ok)
            inv_pass <= 1'b0;
        else if ((state == S_READ_WAIT) && rd_done && is_last)
            inv_pass <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_mem_test_ctrl.sv
// Directed bench: two controller instances, each with a behavioural
// accumulator and a 1-cycle-latency memory model that can corrupt or drop reads.
module tb_mem_test_ctrl;

`ifdef MEMTEST_INV_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: p_LAST_ADDR=3 ----------------
    logic       rst_a, start_a, acc_en_a, acc_rst_a, we_a, re_a, rvalid_a;
    logic       busy_a, done_a, pass_a, tmo_a;
    logic [7:0] addr_a, maddr_a, wdata_a, rdata_a, err_a, first_a;
    logic [7:0] mem_a [4];
    logic [7:0] wlog_a [64];
    int         wlog_n_a = 0;
    int         re_cyc_a [4];
    int         corrupt_a, drop_a;

    mem_test_ctrl #(.p_ADDR_WIDTH(8), .p_DATA_WIDTH(8), .p_LAST_ADDR(3),
                    .p_PATTERN(8'hA5), .p_TIMEOUT(16), .p_ERR_WIDTH(8)) dut_a (
        .i_CLK(clk), .i_RST(rst_a), .i_START(start_a), .i_ADDR(addr_a),
        .o_ACC_ENABLE(acc_en_a), .o_ACC_RST_CONTROL(acc_rst_a),
        .o_MEM_WE(we_a), .o_MEM_RE(re_a), .o_MEM_ADDR(maddr_a), .o_MEM_WDATA(wdata_a),
        .i_MEM_RDATA(rdata_a), .i_MEM_RVALID(rvalid_a),
        .o_BUSY(busy_a), .o_DONE(done_a), .o_PASS(pass_a), .o_ERR_COUNT(err_a),
        .o_FIRST_ERR_ADDR(first_a), .o_TIMEOUT(tmo_a));

    always @(posedge clk or posedge rst_a) begin
        if (rst_a)          addr_a <= 8'd0;
        else if (acc_rst_a) addr_a <= 8'd0;
        else if (acc_en_a)  addr_a <= addr_a + 8'd1;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we_a) begin
            mem_a[maddr_a[1:0]]   <= wdata_a;
            wlog_a[wlog_n_a % 64] <= wdata_a;
            wlog_n_a              <= wlog_n_a + 1;
        end
        if (re_a) re_cyc_a[maddr_a[1:0]] <= cyc;
        rvalid_a <= re_a && (int'(maddr_a) != drop_a);
        rdata_a  <= mem_a[maddr_a[1:0]] ^ ((int'(maddr_a) == corrupt_a) ? 8'h01 : 8'h00);
    end

    // ---------------- instance B: p_LAST_ADDR=255, 4-bit error count ----------------
    logic       rst_b, start_b, acc_en_b, acc_rst_b, we_b, re_b, rvalid_b;
    logic       busy_b, done_b, pass_b, tmo_b, corrupt_all_b;
    logic [7:0] addr_b, maddr_b, wdata_b, rdata_b, first_b;
    logic [3:0] err_b;
    logic [7:0] mem_b [256];

    mem_test_ctrl #(.p_ADDR_WIDTH(8), .p_DATA_WIDTH(8), .p_LAST_ADDR(255),
                    .p_PATTERN(8'hA5), .p_TIMEOUT(16), .p_ERR_WIDTH(4)) dut_b (
        .i_CLK(clk), .i_RST(rst_b), .i_START(start_b), .i_ADDR(addr_b),
        .o_ACC_ENABLE(acc_en_b), .o_ACC_RST_CONTROL(acc_rst_b),
        .o_MEM_WE(we_b), .o_MEM_RE(re_b), .o_MEM_ADDR(maddr_b), .o_MEM_WDATA(wdata_b),
        .i_MEM_RDATA(rdata_b), .i_MEM_RVALID(rvalid_b),
        .o_BUSY(busy_b), .o_DONE(done_b), .o_PASS(pass_b), .o_ERR_COUNT(err_b),
        .o_FIRST_ERR_ADDR(first_b), .o_TIMEOUT(tmo_b));

    always @(posedge clk or posedge rst_b) begin
        if (rst_b)          addr_b <= 8'd0;
        else if (acc_rst_b) addr_b <= 8'd0;
        else if (acc_en_b)  addr_b <= addr_b + 8'd1;
    end

    always @(posedge clk) begin
        if (we_b) mem_b[maddr_b] <= wdata_b;
        rvalid_b <= re_b;
        rdata_b  <= mem_b[maddr_b] ^ (corrupt_all_b ? 8'h01 : 8'h00);
    end

    // Pulse start for one cycle; returns at the negedge where the DUT is in INIT.
    task automatic pulse_start(input bit b);
        @(negedge clk);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit b, input int budget, input string tag);
        int n = 0;
        while (!(b ? done_b : done_a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, b ? done_b : done_a, 1'b1);
    endtask

    int wb;
    int found;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        corrupt_a = -1; drop_a = -1; corrupt_all_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outs_a",
                  {acc_en_a, acc_rst_a, we_a, re_a, busy_a, done_a, pass_a, tmo_a,
                   err_a, first_a, maddr_a, wdata_a}, 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Ideal memory: writes A5,A4,A7,A6 then a clean read pass.
        wb = wlog_n_a;
        pulse_start(1'b0);
        check_val("init_accrst", acc_rst_a, 1'b1);
        check_val("init_busy", busy_a, 1'b1);
        @(negedge clk);
        check_val("wr0_strobe", {we_a, maddr_a, wdata_a}, {1'b1, 8'h00, 8'hA5});
        wait_done(1'b0, 500, "done_ideal");
        check_val("pass_ideal", pass_a, 1'b1);
        check_val("err_ideal", err_a, 8'd0);
        check_val("busy_after", busy_a, 1'b0);
        check_val("wdata0", wlog_a[(wb + 0) % 64], 8'hA5);
        check_val("wdata1", wlog_a[(wb + 1) % 64], 8'hA4);
        check_val("wdata2", wlog_a[(wb + 2) % 64], 8'hA7);
        check_val("wdata3", wlog_a[(wb + 3) % 64], 8'hA6);
`ifdef MEMTEST_INV_PASS_EN
        check_val("inv_wdata0", wlog_a[(wb + 4) % 64], 8'h5A);
        check_val("inv_wdata3", wlog_a[(wb + 7) % 64], 8'h59);
`endif
        check_val("write_count", wlog_n_a - wb, 4 * NPASS);

        // Read at address 2 corrupted (bit 0 flipped); restart from DONE clears status.
        corrupt_a = 2;
        pulse_start(1'b0);
        check_val("clear_done", done_a, 1'b0);
        wait_done(1'b0, 500, "done_corrupt");
        check_val("pass_corrupt", pass_a, 1'b0);
        check_val("err_corrupt", err_a, 8'(NPASS));
        check_val("first_corrupt", first_a, 8'd2);
        check_val("tmo_corrupt", tmo_a, 1'b0);
        corrupt_a = -1;

        // Address 1 never answers: 16-cycle timeout, then the test carries on.
        drop_a = 1;
        pulse_start(1'b0);
        check_val("clear_err", err_a, 8'd0);
        wait_done(1'b0, 1000, "done_timeout");
        check_val("tmo_flag", tmo_a, 1'b1);
        check_val("err_timeout", err_a, 8'(NPASS));
        check_val("first_timeout", first_a, 8'd1);
        check_val("pass_timeout", pass_a, 1'b0);
        check_val("tmo_gap", re_cyc_a[2] - re_cyc_a[1], 17);
        check_val("normal_gap", re_cyc_a[1] - re_cyc_a[0], 2);
        drop_a = -1;

        // Start pulsed mid-test is ignored: no restart, no extra writes.
        wb = wlog_n_a;
        pulse_start(1'b0);
        repeat (6) @(negedge clk);
        check_val("busy_mid", busy_a, 1'b1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 500, "done_ignore");
        check_val("pass_ignore", pass_a, 1'b1);
        check_val("writes_ignore", wlog_n_a - wb, 4 * NPASS);

        // Instance B: reset asserted while writing address 5.
        pulse_start(1'b1);
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            if (we_b && maddr_b == 8'd5) found = 1;
            else @(negedge clk);
        end
        check_val("reach_addr5", found, 1);
        #1 rst_b = 1'b1;
        #1;
        check_val("async_rst_outs",
                  {acc_en_b, acc_rst_b, we_b, re_b, busy_b, done_b, pass_b, tmo_b,
                   err_b, first_b, maddr_b, wdata_b}, 64'd0);
        @(negedge clk);
        check_val("rst_held_we", {we_b, re_b}, 2'b00);
        rst_b = 1'b0;
        pulse_start(1'b1);
        @(negedge clk);
        check_val("restart_addr0", {we_b, maddr_b, wdata_b}, {1'b1, 8'h00, 8'hA5});
        wait_done(1'b1, 5000, "done_restart");
        check_val("pass_restart", pass_b, 1'b1);
        check_val("err_restart", err_b, 4'd0);

        // Every read corrupted: 4-bit counter saturates at 15.
        corrupt_all_b = 1'b1;
        pulse_start(1'b1);
        wait_done(1'b1, 5000, "done_sat");
        check_val("err_sat", err_b, 4'd15);
        check_val("first_sat", first_b, 8'd0);
        check_val("pass_sat", pass_b, 1'b0);
        check_val("tmo_sat", tmo_b, 1'b0);
        corrupt_all_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
